instr_fetch_unit: RTL and testbench

Upstream neighbour of the immediate extender: holds the PC, fetches 32-bit instructions from an instruction memory over a req/ack handshake, and presents the current instruction to the decoder and immediate extender.
It computes the next PC from either pc+4 or pc+imm_ext, driven by the decoder's branch decision.
It holds each instruction stable until the core retires it, and keeps a retired-instruction counter.

---
 rtl/instr_fetch_unit_if.sv | 18 +
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// +----------------------------------------------------------------------+
// | Module   : instr_fetch_unit_if                                       |
// | Brief    : Instruction-memory req/ack bus between fetch unit and IMEM |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +----------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                          |
// | Brief    : PC holder and req/ack instruction fetcher; optional        |
// |            misaligned-target trap under FETCH_MISALIGN_CHECK_EN       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master imem_bus,
    output logic [31:0]        instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pc_src,
    input  logic [31:0]        imm_ext,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instret,
    output logic               misalign_fault
);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;
`endif

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_req, w_req_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_instret, w_instret_nxt;
    logic [31:0] w_sum;
    logic [31:0] w_target;

    assign w_sum = pc_src ? (r_pc + imm_ext) : (r_pc + 32'd4);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault, w_fault_nxt;
    // Keep the raw target so a trapped PC shows exactly where the branch pointed.
    assign w_target       = w_sum;
    assign misalign_fault = r_fault;
`else
    assign w_target       = w_sum & ~32'd3;
    assign misalign_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_req     <= 1'b0;
            r_addr    <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
            r_instret <= 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_fault   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_req     <= w_req_nxt;
            r_addr    <= w_addr_nxt;
            r_instr   <= w_instr_nxt;
            r_valid   <= w_valid_nxt;
            r_instret <= w_instret_nxt;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_fault   <= w_fault_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_req_nxt     = r_req;
        w_addr_nxt    = r_addr;
        w_instr_nxt   = r_instr;
        w_valid_nxt   = r_valid;
        w_instret_nxt = r_instret;
`ifdef FETCH_MISALIGN_CHECK_EN
        w_fault_nxt   = r_fault;
`endif
        case (r_state)
            S_IDLE: begin
                w_req_nxt   = 1'b1;
                w_addr_nxt  = r_pc;
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_bus.imem_ack) begin
                    w_instr_nxt = imem_bus.imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    w_instret_nxt = r_instret + 32'd1;
                    w_valid_nxt   = 1'b0;
                    w_instr_nxt   = NOP_INSTR;
                    w_pc_nxt      = w_target;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (w_target[1:0] != 2'b00) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_addr_nxt  = w_target;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
`else
                    w_addr_nxt  = w_target;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_FETCH;
`endif
                end
            end
            // S_FAULT (when present) holds everything until reset.
            default: ;
        endcase
    end

    assign imem_bus.imem_req  = r_req;
    assign imem_bus.imem_addr = r_addr;
    assign instr              = r_instr;
    assign instr_valid        = r_valid;
    assign pc                 = r_pc;
    assign pc_plus4           = r_pc + 32'd4;
    assign instret            = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +----------------------------------------------------------------------+
// | Module   : tb_instr_fetch_unit                                       |
// | Brief    : Directed + randomized self-checking bench for fetch unit   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0100;
    localparam logic [31:0] c_nop      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] imm_ext = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;
    logic        misalign_fault;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the core should currently expose.
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_instr;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(
        .RESET_PC  (c_reset_pc),
        .NOP_INSTR (c_nop)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_bus       (imem_bus),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .pc_src         (pc_src),
        .imm_ext        (imm_ext),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .instret        (instret),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_req"},     imem_bus.imem_req, 1'b0);
        check ({tag, "_addr"},    imem_bus.imem_addr, c_reset_pc);
        check ({tag, "_instr"},   instr, c_nop);
        check1({tag, "_valid"},   instr_valid, 1'b0);
        check ({tag, "_instret"}, instret, 32'd0);
        check ({tag, "_pc"},      pc, c_reset_pc);
        check1({tag, "_fault"},   misalign_fault, 1'b0);
    endtask

    // Called one step after an edge with the unit waiting on a fetch.
    task automatic fetch(input int delay, input logic [31:0] data);
        for (int i = 0; i < delay; i++) begin
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = $urandom;
            instr_ready         = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check1("wait_req",   imem_bus.imem_req, 1'b1);
            check ("wait_addr",  imem_bus.imem_addr, m_pc);
            check1("wait_valid", instr_valid, 1'b0);
            check ("wait_instr", instr, c_nop);
        end
        instr_ready         = 1'b0;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = data;
        @(posedge clk); #1;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = $urandom;
        m_instr = data;
        check ("fetch_instr", instr, m_instr);
        check1("fetch_valid", instr_valid, 1'b1);
        check1("fetch_req",   imem_bus.imem_req, 1'b0);
        check ("fetch_pc",    pc, m_pc);
    endtask

    task automatic retire(input logic src, input logic [31:0] imm, input int stall);
        logic [31:0] tgt;
        for (int i = 0; i < stall; i++) begin
            instr_ready         = 1'b0;
            imem_bus.imem_ack   = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom;
            pc_src              = 1'($urandom_range(0, 1));
            imm_ext             = $urandom;
            @(posedge clk); #1;
            check ("hold_instr",   instr, m_instr);
            check ("hold_pc",      pc, m_pc);
            check ("hold_instret", instret, m_instret);
            check1("hold_req",     imem_bus.imem_req, 1'b0);
            check1("hold_valid",   instr_valid, 1'b1);
        end
        imem_bus.imem_ack = 1'b0;
        instr_ready       = 1'b1;
        pc_src            = src;
        imm_ext           = imm;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        pc_src      = 1'($urandom_range(0, 1));
        imm_ext     = $urandom;

        tgt = src ? (m_pc + imm) : (m_pc + 32'd4);
        m_instret = m_instret + 32'd1;
        m_instr   = c_nop;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) begin
            m_pc = tgt;
            check1("mis_fault",   misalign_fault, 1'b1);
            check ("mis_pc",      pc, m_pc);
            check1("mis_req",     imem_bus.imem_req, 1'b0);
            check1("mis_valid",   instr_valid, 1'b0);
            check ("mis_instret", instret, m_instret);
            for (int i = 0; i < 6; i++) begin
                imem_bus.imem_ack = 1'($urandom_range(0, 1));
                instr_ready       = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                check1("mis_stuck_req",   imem_bus.imem_req, 1'b0);
                check1("mis_stuck_fault", misalign_fault, 1'b1);
                check ("mis_stuck_pc",    pc, m_pc);
            end
            imem_bus.imem_ack = 1'b0;
            instr_ready       = 1'b0;
            return;
        end
`else
        tgt = tgt & ~32'd3;
`endif
        m_pc = tgt;
        check ("ret_addr",    imem_bus.imem_addr, m_pc);
        check ("ret_pc",      pc, m_pc);
        check ("ret_plus4",   pc_plus4, m_pc + 32'd4);
        check1("ret_req",     imem_bus.imem_req, 1'b1);
        check1("ret_valid",   instr_valid, 1'b0);
        check ("ret_instr",   instr, c_nop);
        check ("ret_instret", instret, m_instret);
        check1("ret_fault",   misalign_fault, 1'b0);
    endtask

    initial begin
        logic [31:0] imm;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'd0;
        m_pc      = c_reset_pc;
        m_instret = 32'd0;
        m_instr   = c_nop;

        // Power-on reset and the single idle cycle before the first request.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check1("start_req",  imem_bus.imem_req, 1'b1);
        check ("start_addr", imem_bus.imem_addr, c_reset_pc);

        // Sequential fetch with zero-wait ack, then pc+4 retire.
        fetch(0, 32'h0050_0093);
        retire(1'b0, 32'd0, 0);

        // Delayed ack, back-pressure with spurious acks, backward branch.
        fetch(3, $urandom);
        retire(1'b1, 32'hFFFF_FFF8, 5);
        fetch(0, $urandom);
        retire(1'b1, 32'h0000_0020, 0);

        // Randomized fetch/retire traffic.
        for (int k = 0; k < 10; k++) begin
            imm = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            imm[1:0] = 2'b00;
`endif
            fetch($urandom_range(0, 3), $urandom);
            retire(1'($urandom_range(0, 1)), imm, $urandom_range(0, 3));
        end

        // Steer pc to the top of the address space, then wrap through pc+4.
        fetch(1, $urandom);
        retire(1'b1, 32'hFFFF_FFFC - m_pc, 0);
        fetch(0, $urandom);
        retire(1'b0, 32'd0, 1);
        check("wrap_addr_zero", imem_bus.imem_addr, 32'd0);

        // Asynchronous reset in the middle of an outstanding fetch.
        @(posedge clk); #1;
        check1("midfetch_req", imem_bus.imem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_pc      = c_reset_pc;
        m_instret = 32'd0;
        m_instr   = c_nop;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check1("restart_req",  imem_bus.imem_req, 1'b1);
        check ("restart_addr", imem_bus.imem_addr, c_reset_pc);

        // Misaligned branch target from pc=0x100.
        fetch(0, $urandom);
        retire(1'b1, 32'h0000_0006, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
